// File: rtl/serial_sub16.sv
// serial_sub16: digit-serial 16-bit subtractor, c = a - b, LSB digit first.
// DIGIT_W bits are processed per cycle over N_STEPS = 16/DIGIT_W RUN cycles.
// It presents the same five status flags as the combinational 16-bit adder.
// Optional build macro SERIAL_SUB16_ADD_MODE_EN adds an 'op' input.
// With op=1 the block computes a + b instead of a - b.
module serial_sub16 #(
    parameter int DIGIT_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
`ifdef SERIAL_SUB16_ADD_MODE_EN
    input  logic        op,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] c,
    output logic        sign,
    output logic        zero,
    output logic        carry,
    output logic        parity,
    output logic        overflow
);

    localparam int N_STEPS = 16 / DIGIT_W;
    localparam logic [3:0] LAST_STEP = 4'(N_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject digit widths that do not divide 16 into a power-of-two step count
    generate
        if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
              DIGIT_W == 8 || DIGIT_W == 16)) begin : g_bad_digit_w
            $error("serial_sub16: DIGIT_W must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]         state;
    logic [3:0]         step;
    logic [15:0]        a_sh;
    logic [15:0]        b_sh;
    logic [15:0]        r_sh;
    logic               borrow;
    logic               a_msb;
    logic               b_msb;
    logic               is_add;
    logic               accept;
    logic [DIGIT_W-1:0] a_sl;
    logic [DIGIT_W-1:0] b_eff;
    logic               cin;
    logic [DIGIT_W:0]   sum;
    logic               borrow_nxt;
    logic [15:0]        r_nxt;
    logic               ovf_nxt;

`ifdef SERIAL_SUB16_ADD_MODE_EN
    logic op_q;
    assign is_add = op_q;
`else
    assign is_add = 1'b0;
`endif

    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign accept = start && (state == S_IDLE || state == S_DONE);

    // One digit slice: subtraction is a + ~b + ~borrow; in add mode the
    // borrow register holds the running carry instead
    always_comb begin
        a_sl       = a_sh[DIGIT_W-1:0];
        b_eff      = is_add ? b_sh[DIGIT_W-1:0] : ~b_sh[DIGIT_W-1:0];
        cin        = is_add ? borrow : ~borrow;
        sum        = {1'b0, a_sl} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        borrow_nxt = is_add ? sum[DIGIT_W] : ~sum[DIGIT_W];
        r_nxt      = (r_sh >> DIGIT_W) | (16'(sum[DIGIT_W-1:0]) << (16 - DIGIT_W));
        if (is_add) begin
            ovf_nxt = (a_msb == b_msb) && (r_nxt[15] != a_msb);
        end else begin
            ovf_nxt = (a_msb != b_msb) && (r_nxt[15] != a_msb);
        end
    end

    // Control: IDLE -> RUN on accept, RUN counts N_STEPS digits, DONE lasts one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    step  <= 4'd0;
                    state <= accept ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    if (step == LAST_STEP) begin
                        step  <= 4'd0;
                        state <= S_DONE;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                default: begin
                    step  <= 4'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, shift digits through RUN, and
    // publish result and flags only on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= 16'h0000;
            b_sh     <= 16'h0000;
            r_sh     <= 16'h0000;
            borrow   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
`ifdef SERIAL_SUB16_ADD_MODE_EN
            op_q     <= 1'b0;
`endif
            c        <= 16'h0000;
            sign     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            r_sh   <= 16'h0000;
            borrow <= 1'b0;
            a_msb  <= a[15];
            b_msb  <= b[15];
`ifdef SERIAL_SUB16_ADD_MODE_EN
            op_q   <= op;
`endif
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> DIGIT_W;
            b_sh   <= b_sh >> DIGIT_W;
            r_sh   <= r_nxt;
            borrow <= borrow_nxt;
            if (step == LAST_STEP) begin
                c        <= r_nxt;
                sign     <= r_nxt[15];
                zero     <= (r_nxt == 16'h0000);
                carry    <= borrow_nxt;
                parity   <= ~(^r_nxt);
                overflow <= ovf_nxt;
            end
        end
    end

endmodule
